// File: rtl/ls_pkg.sv
// Shared definitions for the ls259 addressable latch: latch geometry,
// the operating-mode enum and the (G, CLR) mode decode.
package ls_pkg;

  localparam int LATCH_W = 8;
  localparam int ADDR_W  = 3;

  typedef enum logic [1:0] {
    ADDR_LATCH = 2'd0,
    MEMORY     = 2'd1,
    DEMUX      = 2'd2,
    CLEAR      = 2'd3
  } mode_e;

  // Map the active-low enable/clear pair onto an operating mode.
  // Anything that is not a clean 0/1 pattern falls into CLEAR, the safe state.
  function automatic mode_e decode_mode(input logic g, input logic clr);
    mode_e m;
    case ({g, clr})
      2'b01:   m = ADDR_LATCH;
      2'b11:   m = MEMORY;
      2'b00:   m = DEMUX;
      2'b10:   m = CLEAR;
      default: m = CLEAR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ls_dec3to8.sv
// Combinational one-hot 3-to-8 decoder with an active-high enable.
module ls_dec3to8
  import ls_pkg::*;
(
  input  logic               en,
  input  logic [ADDR_W-1:0]  sel,
  output logic [LATCH_W-1:0] onehot
);

  // Drive the selected bit high only while enabled.
  always_comb begin
    onehot = {LATCH_W{1'b0}};
    if (en) begin
      onehot[sel] = 1'b1;
    end else begin
      onehot = {LATCH_W{1'b0}};
    end
  end

endmodule

// File: rtl/ls259_addr_latch.sv
// 8-bit addressable latch (74x259 behaviour, cycle-quantised).
// Optional input register stage ahead of mode/address decode; outputs are
// always taken straight from the q_r flops.
module ls259_addr_latch
  import ls_pkg::*;
#(
  parameter int IN_REG = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic s0,
  input  logic s1,
  input  logic s2,
  input  logic d,
  input  logic g,    // enable, active-low
  input  logic clr,  // clear, active-low
  output logic q0,
  output logic q1,
  output logic q2,
  output logic q3,
  output logic q4,
  output logic q5,
  output logic q6,
  output logic q7
);

  // Sampled view of the control inputs (registered or direct).
  logic              g_s;
  logic              clr_s;
  logic [ADDR_W-1:0] addr_s;
  logic              d_s;

  mode_e             mode_s;
  logic              wr_en_s;
  logic [LATCH_W-1:0] sel_s;
  logic [LATCH_W-1:0] q_next_s;
  logic [LATCH_W-1:0] q_r;

  if (IN_REG != 0) begin : g_in_reg
    logic              g_r;
    logic              clr_r;
    logic [ADDR_W-1:0] addr_r;
    logic              d_r;

    // Input stage; reset parks it in MEMORY so no stale write follows reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        g_r    <= 1'b1;
        clr_r  <= 1'b1;
        addr_r <= {ADDR_W{1'b0}};
        d_r    <= 1'b0;
      end else begin
        g_r    <= g;
        clr_r  <= clr;
        addr_r <= {s2, s1, s0};
        d_r    <= d;
      end
    end

    assign g_s    = g_r;
    assign clr_s  = clr_r;
    assign addr_s = addr_r;
    assign d_s    = d_r;
  end else begin : g_direct
    assign g_s    = g;
    assign clr_s  = clr;
    assign addr_s = {s2, s1, s0};
    assign d_s    = d;
  end

  assign mode_s  = decode_mode(g_s, clr_s);
  assign wr_en_s = (mode_s == ADDR_LATCH) || (mode_s == DEMUX);

  ls_dec3to8 u_dec (
    .en     (wr_en_s),
    .sel    (addr_s),
    .onehot (sel_s)
  );

  // Next latch contents from the mode table.
  always_comb begin
    q_next_s = q_r;
    case (mode_s)
      ADDR_LATCH: q_next_s = (q_r & ~sel_s) | (sel_s & {LATCH_W{d_s}});
      MEMORY:     q_next_s = q_r;
      DEMUX:      q_next_s = sel_s & {LATCH_W{d_s}};
      CLEAR:      q_next_s = {LATCH_W{1'b0}};
      default:    q_next_s = {LATCH_W{1'b0}};
    endcase
  end

  // Output latch register; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= {LATCH_W{1'b0}};
    end else begin
      q_r <= q_next_s;
    end
  end

  assign q0 = q_r[0];
  assign q1 = q_r[1];
  assign q2 = q_r[2];
  assign q3 = q_r[3];
  assign q4 = q_r[4];
  assign q5 = q_r[5];
  assign q6 = q_r[6];
  assign q7 = q_r[7];

endmodule

// File: tb/tb_ls259_addr_latch.sv
// Directed bench for ls259_addr_latch: one DUT per IN_REG setting driven by
// the same inputs, hand-computed checks plus a per-cycle mode-table model.
module tb_ls259_addr_latch;

  logic clk = 1'b0;
  logic rst, s0, s1, s2, d, g, clr;
  logic [2:0] addr;
  logic a0, a1, a2, a3, a4, a5, a6, a7;
  logic b0, b1, b2, b3, b4, b5, b6, b7;
  logic [7:0] qa, qb;          // qa: IN_REG=0, qb: IN_REG=1
  logic [7:0] ma, mb;          // model latch contents
  logic       pg, pclr, pd;    // model of the IN_REG=1 input stage
  logic [2:0] paddr;
  logic [7:0] pat;
  logic       dprev;
  int checks = 0;
  int errors = 0;

  assign {s2, s1, s0} = addr;
  assign qa = {a7, a6, a5, a4, a3, a2, a1, a0};
  assign qb = {b7, b6, b5, b4, b3, b2, b1, b0};

  always #5 clk = ~clk;

  ls259_addr_latch #(.IN_REG(0)) dut_a (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1), .s2(s2), .d(d), .g(g), .clr(clr),
    .q0(a0), .q1(a1), .q2(a2), .q3(a3), .q4(a4), .q5(a5), .q6(a6), .q7(a7));

  ls259_addr_latch #(.IN_REG(1)) dut_b (
    .clk(clk), .rst(rst), .s0(s0), .s1(s1), .s2(s2), .d(d), .g(g), .clr(clr),
    .q0(b0), .q1(b1), .q2(b2), .q3(b3), .q4(b4), .q5(b5), .q6(b6), .q7(b7));

  // 74x259 truth table: (G,CLR) = 01 latch, 11 memory, 00 demux, 10 clear.
  function automatic logic [7:0] mode_table(input logic [7:0] q, input logic mg,
                                            input logic mc, input logic [2:0] ad,
                                            input logic md);
    logic [7:0] r;
    r = q;
    if (mg == 1'b0 && mc == 1'b1) r[ad] = md;
    else if (mg == 1'b1 && mc == 1'b1) r = q;
    else if (mg == 1'b0 && mc == 1'b0) begin r = 8'h00; r[ad] = md; end
    else r = 8'h00;
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: advance models at the rising edge, compare on the falling edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      ma = 8'h00; mb = 8'h00;
      pg = 1'b1; pclr = 1'b1; paddr = 3'd0; pd = 1'b0;
    end else begin
      ma = mode_table(ma, g, clr, addr, d);
      mb = mode_table(mb, pg, pclr, paddr, pd);
      pg = g; pclr = clr; paddr = addr; pd = d;
    end
    @(negedge clk);
    check("sb_inreg0", qa, ma);
    check("sb_inreg1", qb, mb);
  endtask

  initial begin
    ma = 8'h00; mb = 8'h00;
    pg = 1'b1; pclr = 1'b1; paddr = 3'd0; pd = 1'b0;
    rst = 1'b1; g = 1'b1; clr = 1'b1; addr = 3'd0; d = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("reset_a", qa, 8'h00);
    check("reset_b", qb, 8'h00);

    // Release reset: no stale write.
    rst = 1'b0;
    tick();
    check("post_reset_a", qa, 8'h00);
    check("post_reset_b", qb, 8'h00);

    // Single latch write to addr 5, then memory.
    g = 1'b0; clr = 1'b1; addr = 3'd5; d = 1'b1;
    tick();
    check("wr5_lat_a", qa, 8'h20);
    check("wr5_lat_b", qb, 8'h00);
    g = 1'b1; addr = 3'd1; d = 1'b0;
    tick();
    check("wr5_a", qa, 8'h20);
    check("wr5_b", qb, 8'h20);
    for (int i = 0; i < 3; i++) tick();
    check("wr5_hold_a", qa, 8'h20);
    check("wr5_hold_b", qb, 8'h20);

    // Fill to FF, then demux and clear.
    g = 1'b0; clr = 1'b1; d = 1'b1;
    for (int i = 0; i < 8; i++) begin addr = 3'(i); tick(); end
    g = 1'b1;
    tick(); tick();
    check("fill_a", qa, 8'hFF);
    check("fill_b", qb, 8'hFF);
    g = 1'b0; clr = 1'b0; addr = 3'd2; d = 1'b1;
    tick();
    check("demux_a", qa, 8'h04);
    check("demux_lat_b", qb, 8'hFF);
    g = 1'b1; clr = 1'b0;
    tick();
    check("clear_a", qa, 8'h00);
    check("demux_b", qb, 8'h04);
    tick();
    check("clear_b", qb, 8'h00);
    clr = 1'b1;
    tick();

    // Address walk builds 55, then memory ignores addr/D.
    g = 1'b0; clr = 1'b1;
    for (int i = 0; i < 8; i++) begin addr = 3'(i); d = (i % 2 == 0); tick(); end
    g = 1'b1;
    tick(); tick();
    check("walk_a", qa, 8'h55);
    check("walk_b", qb, 8'h55);
    for (int i = 0; i < 20; i++) begin
      addr = 3'($urandom_range(7, 0)); d = 1'($urandom_range(1, 0));
      tick();
      check("mem_a", qa, 8'h55);
      check("mem_b", qb, 8'h55);
    end

    // D toggling on addr 3: Q3 follows with 1 / 2 edge latency.
    g = 1'b0; clr = 1'b1; addr = 3'd3;
    dprev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = (i % 2 == 0);
      tick();
      check("toggle_a", qa, (8'h55 & 8'hF7) | {4'h0, d, 3'b000});
      check("toggle_b", qb, (8'h55 & 8'hF7) | {4'h0, dprev, 3'b000});
      dprev = d;
    end
    g = 1'b1;
    tick(); tick();

    // Load A5, then reset on the same edge as a demux write.
    pat = 8'hA5;
    g = 1'b0; clr = 1'b1;
    for (int i = 0; i < 8; i++) begin addr = 3'(i); d = pat[i]; tick(); end
    g = 1'b1;
    tick(); tick();
    check("a5_a", qa, 8'hA5);
    check("a5_b", qb, 8'hA5);
    g = 1'b0; clr = 1'b0; addr = 3'd0; d = 1'b1; rst = 1'b1;
    tick();
    check("rst_wr_a", qa, 8'h00);
    check("rst_wr_b", qb, 8'h00);
    rst = 1'b0; g = 1'b1; clr = 1'b1;
    tick();
    check("rst_after_a", qa, 8'h00);
    check("rst_after_b", qb, 8'h00);
    tick();
    check("rst_after2_a", qa, 8'h00);
    check("rst_after2_b", qb, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ls259_addr_latch.md
LS259_ADDR_LATCH -- requirements
Module: ls259_addr_latch

Interface
REQ-001 Parameter: IN_REG, default 1, 1 = one input register stage ahead of mode/address decode, 0 = decode direct from ports.
REQ-002 _CLK  in  1  single clock; all state updates on rising edge.
REQ-003 _RST  in  1  reset, synchronous, active-high.
REQ-004 _S0, _S1, _S2  in  1 each  latch address; _S0 LSB, index 0..7.
REQ-005 _D  in  1  data bit written to the addressed latch.
REQ-006 _G  in  1  enable, active-low.
REQ-007 _CLR  in  1  clear, active-low.
REQ-008 _Q0.._Q7  out  1 each  registered latch outputs.

Function
REQ-009 Mode decode from sampled (_G, _CLR) SHALL be: (0,1) ADDR_LATCH; (1,1) MEMORY; (0,0) DEMUX; (1,0) CLEAR.
REQ-010 ADDR_LATCH: Q[addr] <= D; all other Q hold.
REQ-011 MEMORY: all Q hold; D and address ignored.
REQ-012 DEMUX: Q[addr] <= D; all other Q <= 0.
REQ-013 CLEAR: all Q <= 0; D and address ignored.
REQ-014 Latency: with IN_REG=1, Q reflects inputs sampled on edge N at edge N+1 (2 edges from port change); with IN_REG=0, Q reflects inputs at edge N itself (1 edge).
REQ-015 Held G low across successive cycles: each cycle is an independent write; the latch written on a previous cycle keeps its last written value when the address moves.
REQ-016 Address and mode changes in the same cycle: new mode applies with new address; no write to the old address.
REQ-017 D toggling while G low and address stable: Q[addr] follows D with fixed latency (transparent behaviour, cycle-quantised).
REQ-018 No combinational path from any input to any Q; Q driven only from flops.
REQ-019 Outputs SHALL never show X after the first reset edge for any defined input combination.

Reset
REQ-020 _RST high at an edge: all Q <= 0; input register stage <= (_G=1, _CLR=1, address=0, D=0), i.e. MEMORY.
REQ-021 First cycle after reset release: no write from stale pipeline contents; Q stays 0 until a sampled ADDR_LATCH/DEMUX with D=1.
REQ-022 _RST asserted mid-write: reset wins at that edge; the pending write is discarded.

Structure
REQ-023 Shared package ls_pkg SHALL hold the mode enum (ADDR_LATCH, MEMORY, DEMUX, CLEAR) and the latch-width constant (8).
REQ-024 One sub-module ls_dec3to8: combinational one-hot 3-to-8 decoder with active-high enable, reused for the address decode.
REQ-025 Output register held as 8-bit vector internally, split to _Q0.._Q7 at the ports.

Verification
REQ-026 Reset, then G=0,CLR=1, addr=5, D=1 for one cycle, then G=1 -> Q=8'b0010_0000 after stated latency, held indefinitely.
REQ-027 From Q=8'hFF: G=0,CLR=0, addr=2, D=1 -> Q=8'h04; next cycle G=1,CLR=0 -> Q=8'h00.
REQ-028 G=0,CLR=1, walk addr 0..7 with D=1,0,1,0,1,0,1,0 -> Q=8'h55; then G=1, vary addr/D randomly 20 cycles -> Q stays 8'h55.
REQ-029 G=0, addr=3, D toggles each cycle for 6 cycles -> Q3 follows D with exact latency (1 or 2 per IN_REG), other bits unchanged.
REQ-030 Q=8'hA5, assert _RST on the same edge as a DEMUX write (addr=0, D=1) -> Q=8'h00; next edge with G=1 -> Q stays 8'h00.
REQ-031 Run REQ-026..REQ-030 for IN_REG=0 and IN_REG=1; a scoreboard compares Q against a cycle-accurate mode-table model each cycle.
